opc_enc: RTL



---
 rtl/opc_enc.sv | 119 +++++++++++
 1 files changed

// File: rtl/opc_enc.sv
// ============================================================================
//  Module   : opc_enc
//  Brief    : One-hot operation encoder and instruction packer. Legal words
//             go into a show-ahead FIFO; illegal codes are dropped and counted.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opc_enc #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      code_in,
  input  logic [25:0]      fields_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             err_pulse,
  output logic [7:0]       err_cnt,
  output logic [15:0]      issued_cnt,
  output logic [PTR_W:0]   fifo_level
);

  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [15:0]      issued_cnt_q, issued_cnt_d;
  logic [31:0]      mem_q [DEPTH];

  logic       code_legal;
  logic [5:0] opcode;
  logic       accept;
  logic       push;
  logic       pop;

  // Bits 16 and 17 are reserved and never encode an operation.
  always_comb begin
    code_legal = ($countones(code_in) == 1) && !code_in[16] && !code_in[17];
    opcode     = 6'd0;
    for (int k = 0; k < 16; k++) begin
      if (code_in[k]) opcode = 6'(k);
    end
    if (code_in[18]) opcode = 6'd16;
    if (code_in[19]) opcode = 6'd17;
  end

  always_comb begin
    in_ready = (level_q != FULL_LVL);
    out_valid = (level_q != '0);
    accept   = in_valid && in_ready;
    push     = accept && code_legal;
    pop      = out_valid && out_ready;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    err_pulse_d  = accept && !code_legal;
    err_cnt_d    = err_cnt_q;
    issued_cnt_d = issued_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      issued_cnt_d = issued_cnt_q + 16'd1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (accept && !code_legal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
      issued_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      err_pulse_q  <= err_pulse_d;
      err_cnt_q    <= err_cnt_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy guards its validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {opcode, fields_in};
  end

  always_comb begin
    instr_out  = mem_q[rd_ptr_q];
    err_pulse  = err_pulse_q;
    err_cnt    = err_cnt_q;
    issued_cnt = issued_cnt_q;
    fifo_level = level_q;
  end

endmodule

`default_nettype wire
